product_bcd_converter: RTL and testbench
========================================

# product_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 4-bit combinational multiplier. It accepts the 8-bit product `p` through a valid/ready handshake and runs a shift-and-add-3 (double-dabble) loop, one bit per cycle. It then presents hundreds/tens/ones digits for the lab 7-segment display path. Output is held until the consumer accepts it.

## Interface
- `WIDTH`, default 8: binary input width (multiplier product width).
- `DIGITS`, default 3: BCD digit count. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `clk` input 1: single clock. All state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high. Sampled on the rising edge of `clk`.
- `in_valid` input 1: `bin_in` holds a product to convert.
- `in_ready` output 1: converter can accept a product this cycle.
- `bin_in` input WIDTH: binary product (multiplier output `p`).
- `out_valid` output 1: `bcd_out` holds a completed result.
- `out_ready` input 1: consumer accepts `bcd_out` this cycle.
- `bcd_out` output 4·DIGITS: packed digits, ones in [3:0], tens in [7:4], hundreds in [11:8].
- `bin_echo` output WIDTH: copy of the binary value that produced `bcd_out`.
- `busy` output 1: high in SHIFT state.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: conversion running.
  - DONE: `out_valid`=1.
- IDLE → SHIFT on `in_valid && in_ready`. On that edge:
  - load `bin_in` into the binary shift register and into `bin_echo`;
  - clear the BCD accumulator;
  - clear the iteration counter.
- SHIFT, every cycle:
  - each 4-bit BCD digit ≥ 5 gets +3 (digit-wise, no carry between digits);
  - then the concatenation {BCD, binary} shifts left by 1;
  - the counter increments.
- SHIFT → DONE on the edge that completes shift number WIDTH (counter == WIDTH−1). `bcd_out` is updated from the accumulator on that edge.
- DONE → IDLE on `out_valid && out_ready`. `bcd_out` and `bin_echo` remain stable until the next load.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Arithmetic:
  - the digit adjust is 4-bit unsigned;
  - the accumulator is 4·DIGITS bits;
  - with WIDTH=8 the hundreds digit never exceeds 2;
  - any digit value > 9 at DONE is a design error (assertion in bench).
- Reset (any state, including mid-SHIFT):
  - next state IDLE; the conversion in progress is discarded;
  - `bcd_out`=0, `bin_echo`=0, `out_valid`=0, `busy`=0, counter=0;
  - `in_ready` is forced 0 while `rst` is high, and is 1 from the first cycle after release.

## Timing
- Handshake accepted at edge T → `busy` high for cycles T+1..T+WIDTH (8 cycles).
- `out_valid` rises at edge T+WIDTH+1. Latency is 9 cycles for WIDTH=8.
- Minimum spacing between accepted inputs is WIDTH+2 = 10 cycles: 1 IDLE, 8 SHIFT, ≥1 DONE.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There are no combinational paths from `in_valid` or `out_ready` to any output.
- `out_ready` held low stalls in DONE indefinitely with outputs frozen.

## Structure
- Shared package `bcd_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - `BCD_W` = 4;
  - `ADJ_THRESH` = 5;
  - `ADJ_ADD` = 3.
- One sub-module: `bcd_digit_adjust` (combinational, 4-bit in → 4-bit out, +3 when ≥5). Instantiated DIGITS times via generate.
- Top level holds the FSM, counter (width clog2(WIDTH)), shift registers and output registers.

## Test plan
- `bin_in`=0 accepted at edge T → `out_valid` at T+9, `bcd_out`=12'h000, `bin_echo`=0.
- `bin_in`=225 (15×15) → `bcd_out`=12'h225. `busy` high exactly 8 cycles, and `in_ready` low from T+1 until the DONE handshake.
- `bin_in`=99, `out_ready` low for 5 cycles after `out_valid` → `bcd_out`=12'h099 stable all 5 cycles. `in_valid` pulsed with 200 during the stall is ignored. Return to IDLE the cycle after `out_ready`=1.
- `rst` asserted during the 4th SHIFT cycle of `bin_in`=187 → next cycle IDLE, all outputs 0, `in_ready`=0 while `rst` is high. After release, a new input of 42 yields 12'h042.
- Exhaustive: drive `bin_in` = a·b for every a, b in 0..15, with back-to-back handshakes and `out_ready` tied 1 → every `bcd_out` matches decimal a·b, no digit > 9, spacing exactly 10 cycles.
- `in_valid` and `out_ready` both high in DONE → handshake completes and next state is IDLE. The new input is accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned ADJ_THRESH = 5;
    localparam int unsigned ADJ_ADD    = 3;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Input/output handshake bundle between the multiplier, converter and display path.
interface product_bcd_converter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [WIDTH-1:0]      bin_echo;
    logic                  busy;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, bin_echo, busy
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, bin_echo, busy
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit_c
);
    assign o_digit_c = (i_digit >= BCD_W'(ADJ_THRESH)) ? i_digit + BCD_W'(ADJ_ADD)
                                                        : i_digit;
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-and-add-3 converter turning the multiplier product into BCD digits,
// one bit per cycle, with valid/ready handshakes on both sides.
module product_bcd_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    product_bcd_converter_if.slave   bus
);
    localparam int unsigned BCD_TOT = BCD_W * DIGITS;
    localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_bin;
    logic [WIDTH-1:0]     r_echo;
    logic [BCD_TOT-1:0]   r_acc;
    logic [BCD_TOT-1:0]   r_bcd_out;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [BCD_TOT-1:0]   w_acc_adj;
    logic [BCD_TOT-1:0]   w_acc_next;
    logic                 w_unused_msb;

    // Per-digit +3 correction, no carry between digits
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit   (r_acc[g*BCD_W +: BCD_W]),
            .o_digit_c (w_acc_adj[g*BCD_W +: BCD_W])
        );
    end

    // The top accumulator bit shifted out is always zero for legal DIGITS/WIDTH
    assign w_acc_next   = {w_acc_adj[BCD_TOT-2:0], r_bin[WIDTH-1]};
    assign w_unused_msb = w_acc_adj[BCD_TOT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bin       <= '0;
            r_echo      <= '0;
            r_acc       <= '0;
            r_bcd_out   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= SHIFT;
                        r_bin   <= bus.bin_in;
                        r_echo  <= bus.bin_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state     <= DONE;
                        r_bcd_out   <= w_acc_next;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Ready is held off for the whole time reset is asserted
    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.bin_echo  = r_echo;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed checks of the product_bcd_converter handshake, timing and conversion results.
module tb_product_bcd_converter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   cyc;

    product_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

    product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Accept v at the next edge and follow it into the first DONE cycle
    task automatic start_and_wait(input logic [7:0] v, output int busy_cnt);
        busy_cnt = 0;
        check("ready_before_load", 32'(bus.in_ready), 32'd1);
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) step;
            busy_cnt += int'(bus.busy);
            check("busy_window", 32'(bus.busy), (k <= 8) ? 32'd1 : 32'd0);
            check("out_valid_timing", 32'(bus.out_valid), (k == 9) ? 32'd1 : 32'd0);
            check("ready_low_busy", 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic release_done;
        bus.out_ready = 1'b1;
        step;
        bus.out_ready = 1'b0;
        check("release_valid_low", 32'(bus.out_valid), 32'd0);
        check("release_ready_high", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step;
            n++;
        end
        check(tag, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        int bc;
        int acc_cyc;
        int prev_cyc;
        int v;
        int n;
        n_checks     = 0;
        n_err        = 0;
        cyc          = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.bin_in   = '0;

        // Reset state
        step;
        step;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_bcd_out", 32'(bus.bcd_out), 32'h000);
        check("rst_bin_echo", 32'(bus.bin_echo), 32'd0);
        rst = 1'b0;
        step;
        check("ready_after_release", 32'(bus.in_ready), 32'd1);

        // Zero input
        start_and_wait(8'd0, bc);
        check("zero_bcd", 32'(bus.bcd_out), 32'h000);
        check("zero_echo", 32'(bus.bin_echo), 32'd0);
        release_done;

        // 15 x 15
        start_and_wait(8'd225, bc);
        check("busy_count_225", 32'(bc), 32'd8);
        check("bcd_225", 32'(bus.bcd_out), 32'h225);
        check("echo_225", 32'(bus.bin_echo), 32'd225);
        release_done;

        // Stall in DONE with a spurious in_valid
        start_and_wait(8'd99, bc);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_bcd", 32'(bus.bcd_out), 32'h099);
            check("stall_echo", 32'(bus.bin_echo), 32'd99);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = (i == 2);
            bus.bin_in   = 8'd200;
            step;
            bus.in_valid = 1'b0;
        end
        release_done;
        check("stall_bcd_hold", 32'(bus.bcd_out), 32'h099);
        check("stall_echo_hold", 32'(bus.bin_echo), 32'd99);
        check("stall_not_busy", 32'(bus.busy), 32'd0);

        // Reset during the 4th SHIFT cycle
        bus.bin_in   = 8'd187;
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        step;
        step;
        step;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_bcd", 32'(bus.bcd_out), 32'h000);
        check("midrst_echo", 32'(bus.bin_echo), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        step;
        check("midrst_ready_rel", 32'(bus.in_ready), 32'd1);
        start_and_wait(8'd42, bc);
        check("bcd_42", 32'(bus.bcd_out), 32'h042);
        release_done;

        // in_valid and out_ready together in DONE
        start_and_wait(8'd123, bc);
        check("bcd_123", 32'(bus.bcd_out), 32'h123);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.bin_in    = 8'd77;
        step;
        check("both_idle_ready", 32'(bus.in_ready), 32'd1);
        check("both_idle_valid", 32'(bus.out_valid), 32'd0);
        check("both_idle_busy", 32'(bus.busy), 32'd0);
        check("both_echo_old", 32'(bus.bin_echo), 32'd123);
        step;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("both_accept_busy", 32'(bus.busy), 32'd1);
        check("both_accept_echo", 32'(bus.bin_echo), 32'd77);
        wait_out_valid("both_timeout");
        check("bcd_77", 32'(bus.bcd_out), 32'h077);
        release_done;

        // Every 4-bit product, back-to-back
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev_cyc = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                v = a * b;
                n = 0;
                while (!bus.in_ready && n < 20) begin
                    step;
                    n++;
                end
                check("exh_ready_timeout", 32'(bus.in_ready), 32'd1);
                bus.bin_in = 8'(v);
                acc_cyc = cyc;
                if (a != 0 || b != 0)
                    check("exh_spacing", 32'(acc_cyc - prev_cyc), 32'd10);
                prev_cyc = acc_cyc;
                step;
                wait_out_valid("exh_valid_timeout");
                check("exh_bcd", 32'(bus.bcd_out), 32'(to_bcd(v)));
                check("exh_echo", 32'(bus.bin_echo), 32'(v));
                check("exh_digits_le9",
                      32'((bus.bcd_out[3:0] <= 4'd9) && (bus.bcd_out[7:4] <= 4'd9)
                          && (bus.bcd_out[11:8] <= 4'd2)), 32'd1);
                if (a == 15 && b == 15) bus.in_valid = 1'b0;
            end
        end
        step;
        bus.out_ready = 1'b0;
        step;
        check("final_idle_busy", 32'(bus.busy), 32'd0);
        check("final_idle_ready", 32'(bus.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
